core_result_arb: RTL and testbench
==================================

# core_result_arb

Round-robin arbiter sharing the single result write-back port among the 16 shader cores dispatched by the scheduler. Cores post 16-bit result words with a `last` flag. The block grants one core per cycle into a registered valid/ready output stage. It pulses a per-core release vector so the scheduler can clear its exec mask, and tracks a fence (barrier) mask loaded by the scheduler.

## Interface
Parameters:
- `NUM_CORES`, 16: number of requesters; must be a power of two.
- `DATA_W`, 16: result word width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `req`, in, NUM_CORES: per-core request; held until granted.
- `req_data`, in, [NUM_CORES-1:0][DATA_W-1:0]: per-core result word.
- `req_last`, in, NUM_CORES: the word is the core's final result for this frame.
- `grant`, out, NUM_CORES: one-hot or zero, combinational; the core's word is accepted this cycle.
- `out_valid`, out, 1: output register holds a word.
- `out_data`, out, DATA_W: word being delivered.
- `out_core_id`, out, $clog2(NUM_CORES): source core.
- `out_last`, out, 1: copy of `req_last` for the word.
- `out_ready`, in, 1: sink accepts the word.
- `core_release`, out, NUM_CORES: one-cycle pulse per core whose last word was granted.
- `fence_load`, in, 1: load a new fence mask.
- `fence_mask`, in, NUM_CORES: cores to wait for.
- `fence_done`, out, 1: level; all fenced cores released.

## Operation
- Accept condition: `take = !out_valid || out_ready`. Grant is issued only when `take` is true and `req` is nonzero.
- Winner selection:
  - The winner is the first requesting core at or above `rr_ptr`, searching with wrap-around.
  - On a grant to core k, `rr_ptr` becomes (k+1) mod NUM_CORES.
  - With no grant, `rr_ptr` holds.
- Output register:
  - On a grant, it loads data, id and last, and `out_valid` is set to 1.
  - On `out_ready` with no grant, `out_valid` is cleared to 0.
- Release: `core_release[k]` is registered and high for exactly one cycle after the cycle in which `grant[k] && req_last[k]`.
- Fence, `pend` register:
  - On `fence_load`: `pend <= fence_mask & ~rel_now`, where `rel_now` is this cycle's granted-last vector. A last word granted in the load cycle counts as released.
  - Otherwise: `pend <= pend & ~rel_now`.
  - `fence_done = (pend == 0)`, registered. It stays 1 when no fence is pending.
- Fence edge cases:
  - Loading an all-zero mask gives `fence_done` = 1 on the next cycle.
  - A new `fence_load` while a fence is pending overwrites it.
- A request with `req_last` = 0 never affects `pend`.

## Timing
- Reset values, all applied asynchronously:
  - `rr_ptr` = 0; `out_valid` = 0; `out_data`, `out_core_id`, `out_last` = 0.
  - `core_release` = 0; `pend` = 0; `fence_done` = 1.
- Latency:
  - `grant` is combinational in cycle N.
  - The word appears on `out_*` at N+1.
  - `core_release` pulses at N+1.
  - `fence_done` rises at N+1 if that grant cleared the final `pend` bit.
- Throughput: one word per cycle while `out_ready` = 1. Back-pressure suppresses all grants, with no skid buffer.
- Starvation bound: a continuously requesting core is granted within NUM_CORES accept cycles.
- Reset asserted mid-transfer: `out_valid` drops immediately, the in-flight word is discarded, and the pointer returns to 0.

## Configuration
- `ARB_BUSY_CNT_EN`
  - Defined: adds output port `busy_cycles` [31:0].
    - It counts cycles with `out_valid && !out_ready` (sink stall), saturating at 32'hFFFF_FFFF.
    - It resets to 0, and it is also cleared on `fence_load`.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `gpu_pkg` holds the `NUM_CORES` and `DATA_W` defaults and the `core_id_t` typedef ($clog2 width).
- The scheduler imports the same package for `new_act_core` and `exec_mask`.
- One sub-module, `rr_pick`:
  - Combinational rotate–priority-encode–rotate.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot winner and index.

## Test plan
- Single request, `req` = 16'h0001, data 16'hABCD, last = 1, `out_ready` = 1:
  - `grant[0]` in cycle 0.
  - `out_data` = ABCD, id 0, `core_release` = 16'h0001 for exactly one cycle at cycle 1.
- All 16 cores requesting continuously from reset: grant order is 0,1,…,15,0, one per cycle, with `out_valid` held at 1.
- `out_ready` = 0 for 5 cycles with `req` = 16'h0006:
  - `grant` = 0 and the output is held stable.
  - After release, core 1 is granted, then core 2.
- `fence_load` with mask 16'h0081, then cores 0 and 7 send last words 3 cycles apart: `fence_done` = 0 until the cycle after core 7's grant, then 1.
- `fence_load` with mask 16'h0010 in the same cycle that core 4's last word is granted: `fence_done` stays 1.
- Reset pulse while `out_valid` = 1 and `pend` = 16'h00F0:
  - `out_valid` = 0, `fence_done` = 1 and `rr_ptr` = 0 immediately.
  - The next grant goes to the lowest requester.

Source files
------------

// File: rtl/gpu_pkg.sv
// ============================================================================
// Module : gpu_pkg
// Brief  : Shared core-count / result-width defaults and the core id type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

    localparam int NUM_CORES = 16;
    localparam int DATA_W    = 16;

    typedef logic [$clog2(NUM_CORES)-1:0] core_id_t;

endpackage : gpu_pkg

`default_nettype wire

// File: rtl/core_result_arb_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin winner select (rotate, priority-encode,
//          rotate back). Lowest requester at or above rr_ptr wins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_CORES = gpu_pkg::NUM_CORES
) (
    input  logic [NUM_CORES-1:0]         req,
    input  logic [$clog2(NUM_CORES)-1:0] rr_ptr,
    output logic [NUM_CORES-1:0]         win_onehot,
    output logic [$clog2(NUM_CORES)-1:0] win_idx,
    output logic                         win_any
);

    localparam int c_ID_W = $clog2(NUM_CORES);

    logic [2*NUM_CORES-1:0] w_dbl;
    logic [NUM_CORES-1:0]   w_rot;
    logic [c_ID_W-1:0]      w_enc;

    always_comb begin
        // Doubling the vector makes the right shift behave as a rotate.
        w_dbl = {req, req} >> rr_ptr;
        w_rot = w_dbl[NUM_CORES-1:0];
        w_enc = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = c_ID_W'(i);
            end
        end
    end

    // NUM_CORES is a power of two, so the add wraps modulo NUM_CORES.
    assign win_any    = |req;
    assign win_idx    = w_enc + rr_ptr;
    assign win_onehot = win_any ? (NUM_CORES'(1) << win_idx) : '0;

endmodule : rr_pick

`default_nettype wire

// File: rtl/core_result_arb.sv
// ============================================================================
// Module : core_result_arb
// Brief  : Round-robin arbiter for the shared result write-back port, with
//          per-core release pulses and a fence mask. Optional busy_cycles
//          sink-stall counter enabled by macro ARB_BUSY_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_result_arb #(
    parameter int NUM_CORES = gpu_pkg::NUM_CORES,
    parameter int DATA_W    = gpu_pkg::DATA_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                req,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]    req_data,
    input  logic [NUM_CORES-1:0]                req_last,
    output logic [NUM_CORES-1:0]                grant,
    output logic                                out_valid,
    output logic [DATA_W-1:0]                   out_data,
    output logic [$clog2(NUM_CORES)-1:0]        out_core_id,
    output logic                                out_last,
    input  logic                                out_ready,
    output logic [NUM_CORES-1:0]                core_release,
    input  logic                                fence_load,
    input  logic [NUM_CORES-1:0]                fence_mask,
`ifdef ARB_BUSY_CNT_EN
    output logic [31:0]                         busy_cycles,
`endif
    output logic                                fence_done
);

    localparam int c_ID_W = $clog2(NUM_CORES);

    logic [c_ID_W-1:0]    r_rr_ptr;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [c_ID_W-1:0]    r_out_core_id;
    logic                 r_out_last;
    logic [NUM_CORES-1:0] r_release;
    logic [NUM_CORES-1:0] r_pend;
    logic                 r_fence_done;

    logic                 w_take;
    logic                 w_grant_any;
    logic [NUM_CORES-1:0] w_win_onehot;
    logic [c_ID_W-1:0]    w_win_idx;
    logic                 w_win_any;
    logic [NUM_CORES-1:0] w_rel_now;
    logic [NUM_CORES-1:0] w_pend_next;

    rr_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (r_rr_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .win_any    (w_win_any)
    );

    // No skid buffer: a held word blocks every grant until the sink takes it.
    assign w_take      = !r_out_valid || out_ready;
    assign w_grant_any = w_take && w_win_any;
    assign grant       = w_grant_any ? w_win_onehot : '0;
    assign w_rel_now   = grant & req_last;
    assign w_pend_next = fence_load ? (fence_mask & ~w_rel_now) : (r_pend & ~w_rel_now);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_core_id <= '0;
            r_out_last    <= 1'b0;
            r_release     <= '0;
            r_pend        <= '0;
            r_fence_done  <= 1'b1;
        end else begin
            if (w_grant_any) begin
                r_rr_ptr      <= w_win_idx + c_ID_W'(1);
                r_out_valid   <= 1'b1;
                r_out_data    <= req_data[w_win_idx];
                r_out_core_id <= w_win_idx;
                r_out_last    <= req_last[w_win_idx];
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
            r_release    <= w_rel_now;
            r_pend       <= w_pend_next;
            r_fence_done <= (w_pend_next == '0);
        end
    end

`ifdef ARB_BUSY_CNT_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_cycles <= '0;
        end else if (fence_load) begin
            r_busy_cycles <= '0;
        end else if (r_out_valid && !out_ready && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign busy_cycles = r_busy_cycles;
`endif

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_core_id  = r_out_core_id;
    assign out_last     = r_out_last;
    assign core_release = r_release;
    assign fence_done   = r_fence_done;

endmodule : core_result_arb

`default_nettype wire

// File: tb/tb_core_result_arb.sv
// ============================================================================
// Module : tb_core_result_arb
// Brief  : Self-checking bench for core_result_arb (directed + random).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_result_arb;

    localparam int c_N  = 16;
    localparam int c_DW = 16;

    logic                      clk;
    logic                      reset;
    logic [c_N-1:0]            req;
    logic [c_N-1:0][c_DW-1:0]  req_data;
    logic [c_N-1:0]            req_last;
    logic [c_N-1:0]            grant;
    logic                      out_valid;
    logic [c_DW-1:0]           out_data;
    logic [3:0]                out_core_id;
    logic                      out_last;
    logic                      out_ready;
    logic [c_N-1:0]            core_release;
    logic                      fence_load;
    logic [c_N-1:0]            fence_mask;
    logic                      fence_done;
`ifdef ARB_BUSY_CNT_EN
    logic [31:0]               busy_cycles;
`endif

    core_result_arb #(
        .NUM_CORES (c_N),
        .DATA_W    (c_DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .grant        (grant),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_core_id  (out_core_id),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .core_release (core_release),
        .fence_load   (fence_load),
        .fence_mask   (fence_mask),
`ifdef ARB_BUSY_CNT_EN
        .busy_cycles  (busy_cycles),
`endif
        .fence_done   (fence_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (spec-level view of the arbiter)
    int             m_ptr;
    logic           m_valid;
    logic [c_N-1:0] m_rel;
    logic [c_N-1:0] m_pend;
    logic           m_done;
    logic [31:0]    m_busy;
    int             last_win;
    logic [20:0]    sb_q[$];   // {data, id, last}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_rel   = '0;
        m_pend  = '0;
        m_done  = 1'b1;
        m_busy  = '0;
        sb_q.delete();
    endtask

    // Called just after a rising edge with inputs set; checks the cycle at
    // the falling edge and advances the model to the next rising edge.
    task automatic step();
        logic [c_N-1:0] eg;
        logic [c_N-1:0] rel;
        logic           take;
        logic           stall;
        int             win;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("core_release", 32'(core_release), 32'(m_rel));
        chk("fence_done", 32'(fence_done), 32'(m_done));
`ifdef ARB_BUSY_CNT_EN
        chk("busy_cycles", busy_cycles, m_busy);
`endif
        take = !m_valid || out_ready;
        win  = -1;
        if (take) begin
            for (int k = 0; k < c_N; k++) begin
                if (win < 0 && req[(m_ptr + k) % c_N]) win = (m_ptr + k) % c_N;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        rel   = eg & req_last;
        stall = m_valid && !out_ready;
        if (win >= 0) begin
            sb_q.push_back({req_data[win], 4'(win), req_last[win]});
            m_valid = 1'b1;
            m_ptr   = (win + 1) % c_N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        m_rel  = rel;
        m_pend = fence_load ? (fence_mask & ~rel) : (m_pend & ~rel);
        m_done = (m_pend == '0);
        if (fence_load) m_busy = '0;
        else if (stall && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 32'd1;
        last_win = win;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted output word must match the oldest grant.
    initial begin
        logic [20:0] exp_w;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_word", {11'd0, out_data, out_core_id, out_last}, 32'h1FFFFF);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("sb_word", {11'd0, out_data, out_core_id, out_last}, {11'd0, exp_w});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req        = '0;
        req_data   = '0;
        req_last   = '0;
        fence_load = 1'b0;
        fence_mask = '0;
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear right away.
    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fence_done", 32'(fence_done), 32'd1);
        chk("rst_core_release", 32'(core_release), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_core_id", 32'(out_core_id), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [c_N-1:0]           r_hold;
    logic [c_N-1:0][c_DW-1:0] r_hdata;
    logic [c_N-1:0]           r_hlast;

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        step();

        // Single request from core 0
        req = 16'h0001; req_data[0] = 16'hABCD; req_last = 16'h0001;
        step();
        chk("single_data", 32'(out_data), 32'h0000ABCD);
        chk("single_id", 32'(out_core_id), 32'd0);
        chk("single_release", 32'(core_release), 32'h0001);
        idle_inputs();
        step();
        chk("single_release_gone", 32'(core_release), 32'h0000);

        // All cores requesting from reset
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k < c_N; k++) req_data[k] = 16'(16'h1000 + k);
        for (int i = 0; i < 17; i++) begin
            step();
            chk("rr_order", 32'(last_win), 32'(i % c_N));
            chk("rr_valid_held", 32'(out_valid), 32'd1);
        end

        // Back-pressure with cores 1 and 2 requesting
        req = 16'h0006; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_no_grant", 32'(last_win), 32'hFFFF_FFFF);
            chk("bp_id_stable", 32'(out_core_id), 32'd0);
            chk("bp_data_stable", 32'(out_data), 32'h1000);
        end
        out_ready = 1'b1;
        step();
        chk("bp_first", 32'(last_win), 32'd1);
        req = 16'h0004;
        step();
        chk("bp_second", 32'(last_win), 32'd2);
        idle_inputs();
        step();

        // Fence on cores 0 and 7, last words three cycles apart
        fence_load = 1'b1; fence_mask = 16'h0081;
        step();
        idle_inputs();
        chk("fence_armed", 32'(fence_done), 32'd0);
        req = 16'h0001; req_last = 16'h0001;
        step();
        idle_inputs();
        step();
        step();
        chk("fence_partial", 32'(fence_done), 32'd0);
        req = 16'h0080; req_last = 16'h0080;
        step();
        idle_inputs();
        chk("fence_complete", 32'(fence_done), 32'd1);

        // Fence load coinciding with the fenced core's last grant
        req = 16'h0010; req_last = 16'h0010; fence_load = 1'b1; fence_mask = 16'h0010;
        step();
        idle_inputs();
        chk("fence_same_cycle", 32'(fence_done), 32'd1);
        step();
        chk("fence_same_cycle_hold", 32'(fence_done), 32'd1);

        // Reset mid-transfer with a pending fence and nonzero pointer
        req = 16'h0200; fence_load = 1'b1; fence_mask = 16'h00F0; out_ready = 1'b0;
        step();
        idle_inputs();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_fence", 32'(fence_done), 32'd0);
        do_reset();
        out_ready = 1'b1;
        req = 16'h0600;
        step();
        chk("post_rst_lowest", 32'(last_win), 32'd9);
        idle_inputs();
        step();

        // Randomized traffic
        r_hold = '0; r_hdata = '0; r_hlast = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < c_N; k++) begin
                if (!r_hold[k] && $urandom_range(3) == 0) begin
                    r_hold[k]  = 1'b1;
                    r_hdata[k] = 16'($urandom);
                    r_hlast[k] = 1'($urandom);
                end
            end
            req        = r_hold;
            req_data   = r_hdata;
            req_last   = r_hlast;
            out_ready  = ($urandom_range(3) != 0);
            fence_load = ($urandom_range(15) == 0);
            fence_mask = 16'($urandom);
            step();
            if (last_win >= 0) r_hold[last_win] = 1'b0;
        end

        idle_inputs();
        out_ready = 1'b1;
        repeat (3) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_core_result_arb

`default_nettype wire
